xort_pulse_driver: RTL and testbench

Synchronous stimulus/response driver for toggle-encoded SFQ cell models of the clocked XOR (XOR-T) family: accepts binary operand pairs over a valid/ready handshake, emits edge-encoded pulses on the cell's `a`, `b` and `clk` lines, and checks the cell's `out` toggle against the expected XOR. It is the transmitting and observing end of the cell's pulse interface and sits between a bench sequencer and the cell model. Every level change (0→1 or 1→0) on a pulse line is one SFQ pulse.

---
 rtl/xort_pulse_driver.sv | 181 ++++++++++++++++++
 tb/tb_xort_pulse_driver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xort_pulse_driver.sv
// Stimulus/response driver for toggle-encoded XOR-T cell models: sends a, b and
// clk pulses as level changes, then checks the cell's out toggle against a ^ b.
module xort_pulse_driver #(
  parameter int SEP_CYC = 14,
  parameter int OUT_WIN = 12,
  parameter int GAP_CYC = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  // Handshake: an operand pair transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready is high only in IDLE, and operands must be
  // held stable by the sender until that edge.
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_a,
  input  logic       in_b,
  output logic       a_o,
  output logic       b_o,
  output logic       clk_o,
  input  logic       out_i,
  output logic       res_valid,
  output logic       res_bit,
  output logic       res_err,
  output logic       spur_err,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PB   = 3'd1;
  localparam logic [2:0] S_SEP  = 3'd2;
  localparam logic [2:0] S_CK   = 3'd3;
  localparam logic [2:0] S_WIN  = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  localparam int CW = 8;
  localparam logic [CW-1:0] SEP_LD = CW'(SEP_CYC);
  localparam logic [CW-1:0] WIN_LD = CW'(OUT_WIN);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYC);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_a_q, op_a_d;
  logic          op_b_q, op_b_d;
  logic          a_q, a_d;
  logic          b_q, b_d;
  logic          ck_q, ck_d;
  logic          prev_q;
  logic [1:0]    tcnt_q, tcnt_d;
  logic          xseen_q, xseen_d;
  logic          res_valid_q, res_valid_d;
  logic          res_bit_q, res_bit_d;
  logic          res_err_q, res_err_d;
  logic          spur_q, spur_d;

  logic          out_edge;
  logic          out_unknown;
  logic          in_window;
  logic [1:0]    tcnt_inc;
  logic [1:0]    tcnt_win;
  logic          x_win;

  always_comb begin
    out_edge    = (out_i != prev_q);
    out_unknown = (out_i !== 1'b0) && (out_i !== 1'b1);
    in_window   = (state_q == S_CK) || (state_q == S_WIN);
    tcnt_inc    = (tcnt_q == 2'd3) ? 2'd3 : (tcnt_q + 2'd1);
    tcnt_win    = out_edge ? tcnt_inc : tcnt_q;
    x_win       = xseen_q | out_unknown;

    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    a_d         = a_q;
    b_d         = b_q;
    ck_d        = ck_q;
    tcnt_d      = tcnt_q;
    xseen_d     = xseen_q;
    res_valid_d = 1'b0;
    res_bit_d   = res_bit_q;
    res_err_d   = res_err_q;
    spur_d      = spur_q | (out_edge & ~in_window);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          a_d     = in_a ? ~a_q : a_q;
          state_d = S_PB;
        end
      end
      S_PB: begin
        b_d     = op_b_q ? ~b_q : b_q;
        cnt_d   = SEP_LD;
        state_d = S_SEP;
      end
      S_SEP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          state_d = S_CK;
        end
      end
      S_CK: begin
        // The sample on the clk edge itself opens the window.
        ck_d    = ~ck_q;
        tcnt_d  = out_edge ? 2'd1 : 2'd0;
        xseen_d = out_unknown;
        cnt_d   = WIN_LD;
        state_d = S_WIN;
      end
      S_WIN: begin
        tcnt_d  = tcnt_win;
        xseen_d = x_win;
        if (cnt_q == '0) begin
          res_valid_d = 1'b1;
          res_bit_d   = (tcnt_win == 2'd1);
          res_err_d   = (tcnt_win != {1'b0, op_a_q ^ op_b_q}) | x_win;
          cnt_d       = GAP_LD;
          state_d     = S_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_a_q      <= 1'b0;
      op_b_q      <= 1'b0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      ck_q        <= 1'b0;
      prev_q      <= 1'b0;
      tcnt_q      <= 2'd0;
      xseen_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_bit_q   <= 1'b0;
      res_err_q   <= 1'b0;
      spur_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ck_q        <= ck_d;
      prev_q      <= out_i;
      tcnt_q      <= tcnt_d;
      xseen_q     <= xseen_d;
      res_valid_q <= res_valid_d;
      res_bit_q   <= res_bit_d;
      res_err_q   <= res_err_d;
      spur_q      <= spur_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign a_o       = a_q;
  assign b_o       = b_q;
  assign clk_o     = ck_q;
  assign res_valid = res_valid_q;
  assign res_bit   = res_bit_q;
  assign res_err   = res_err_q;
  assign spur_err  = spur_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_xort_pulse_driver.sv
// Bench for xort_pulse_driver: the bench plays the cell, timing every pulse
// relative to the accept edge and scoring results from the XOR rules.
`timescale 1ns/1ps
module tb_xort_pulse_driver;

  localparam int SEP = 14;
  localparam int WIN = 12;
  localparam int GAP = 10;
  localparam int E_CLK  = 2 + SEP;
  localparam int E_RES  = 3 + SEP + WIN;
  localparam int E_LAST = 3 + SEP + WIN + GAP;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_a;
  logic       in_b;
  logic       a_o;
  logic       b_o;
  logic       clk_o;
  logic       out_i;
  logic       res_valid;
  logic       res_bit;
  logic       res_err;
  logic       spur_err;
  logic [2:0] dbg_state;

  xort_pulse_driver #(.SEP_CYC(SEP), .OUT_WIN(WIN), .GAP_CYC(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .a_o       (a_o),
    .b_o       (b_o),
    .clk_o     (clk_o),
    .out_i     (out_i),
    .res_valid (res_valid),
    .res_bit   (res_bit),
    .res_err   (res_err),
    .spur_err  (spur_err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] exp_q[$];
  logic       spur_exp = 1'b0;

  typedef struct {
    logic        a;
    logic        b;
    logic [31:0] tog;
    int          gap_tog;
    logic        exp_bit;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One full operation from the negedge before the accept edge (edge 0) to the
  // edge where in_ready returns. tog bit k toggles out_i so it is sampled k
  // edges after the clk pulse edge; gap_tog >= 0 toggles out_i in GAP.
  task automatic run_op(input logic a, input logic b, input logic [31:0] tog,
                        input int gap_tog, input logic exp_bit,
                        input logic exp_err, input logic junk);
    int a_n = 0, b_n = 0, c_n = 0, r_n = 0;
    int a_e = -1, b_e = -1, c_e = -1, r_e = -1;
    int ready_ok = 1;
    logic pa, pb, pc;
    logic [1:0] exp;
    pa = a_o;
    pb = b_o;
    pc = clk_o;
    exp_q.push_back({exp_bit, exp_err});
    chk("ready_before_op", int'(in_ready), 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int e = 0; e <= E_LAST; e++) begin
      if (e > 0) begin
        if (junk) begin
          in_valid = 1'($urandom_range(0, 1));
          in_a     = 1'($urandom_range(0, 1));
          in_b     = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
      if (e >= E_CLK && e - E_CLK < 32 && tog[e - E_CLK]) out_i = ~out_i;
      if (gap_tog >= 0 && e == E_RES + 1 + gap_tog) out_i = ~out_i;
      @(posedge clk);
      #1;
      if (a_o !== pa) begin a_n++; a_e = e; pa = a_o; end
      if (b_o !== pb) begin b_n++; b_e = e; pb = b_o; end
      if (clk_o !== pc) begin c_n++; c_e = e; pc = clk_o; end
      if (res_valid === 1'b1) begin
        r_n++;
        r_e = e;
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          chk("res_bit", int'(res_bit), int'(exp[1]));
          chk("res_err", int'(res_err), int'(exp[0]));
        end else begin
          chk("res_valid_unexpected", 1, 0);
        end
      end
      if (in_ready !== (e == E_LAST)) ready_ok = 0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (gap_tog >= 0) spur_exp = 1'b1;
    exp_q.delete();
    chk("a_pulse_count", a_n, a ? 1 : 0);
    chk("a_pulse_edge", a_e, a ? 0 : -1);
    chk("b_pulse_count", b_n, b ? 1 : 0);
    chk("b_pulse_edge", b_e, b ? 1 : -1);
    chk("clk_pulse_count", c_n, 1);
    chk("clk_pulse_edge", c_e, E_CLK);
    chk("res_valid_count", r_n, 1);
    chk("res_valid_edge", r_e, E_RES);
    chk("in_ready_profile", ready_ok, 1);
    chk("spur_err", int'(spur_err), int'(spur_exp));
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    int offs[$];
    int k;
    logic ra, rb, rbit, rerr;
    logic [31:0] m;
    int res_n, rdy_ok;

    // Directed table: tog bit k = out_i edge sampled k edges after clk pulse.
    vecs[0] = '{a: 1'b1, b: 1'b0, tog: 32'h0000_0400, gap_tog: -1, exp_bit: 1'b1, exp_err: 1'b0};
    vecs[1] = '{a: 1'b1, b: 1'b1, tog: 32'h0000_0000, gap_tog: -1, exp_bit: 1'b0, exp_err: 1'b0};
    vecs[2] = '{a: 1'b0, b: 1'b0, tog: 32'h0000_0020, gap_tog: -1, exp_bit: 1'b1, exp_err: 1'b1};
    vecs[3] = '{a: 1'b0, b: 1'b1, tog: 32'h0000_0044, gap_tog: -1, exp_bit: 1'b0, exp_err: 1'b1};
    vecs[4] = '{a: 1'b0, b: 1'b1, tog: 32'h0000_0001, gap_tog: -1, exp_bit: 1'b1, exp_err: 1'b0};
    vecs[5] = '{a: 1'b1, b: 1'b0, tog: 32'h0000_0000, gap_tog: -1, exp_bit: 1'b0, exp_err: 1'b1};
    vecs[6] = '{a: 1'b0, b: 1'b0, tog: 32'h0000_0000, gap_tog: -1, exp_bit: 1'b0, exp_err: 1'b0};
    vecs[7] = '{a: 1'b1, b: 1'b1, tog: 32'h0000_002A, gap_tog: -1, exp_bit: 1'b0, exp_err: 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = 1'b0;
    in_b     = 1'b0;
    out_i    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_o", int'(a_o), 0);
    chk("rst_b_o", int'(b_o), 0);
    chk("rst_clk_o", int'(clk_o), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_bit", int'(res_bit), 0);
    chk("rst_res_err", int'(res_err), 0);
    chk("rst_spur_err", int'(spur_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].tog, vecs[i].gap_tog,
             vecs[i].exp_bit, vecs[i].exp_err, 1'b0);
    end

    // Random operations; model: result depends only on how many out_i edges
    // land in the window (saturating at 3) versus a ^ b.
    for (int i = 0; i < 12; i++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      n  = $urandom_range(0, 3);
      offs.delete();
      m = '0;
      while (offs.size() < n) begin
        k = $urandom_range(0, WIN);
        if (!m[k]) begin
          m[k] = 1'b1;
          offs.push_back(k);
        end
      end
      rbit = (offs.size() == 1);
      rerr = (offs.size() != ((ra != rb) ? 1 : 0));
      run_op(ra, rb, m, -1, rbit, rerr, 1'b1);
    end

    // Spurious toggle in GAP, then a clean op must leave spur_err set.
    run_op(1'b1, 1'b0, 32'h0000_0010, 3, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, 1'b1, 32'h0000_0008, -1, 1'b1, 1'b0, 1'b0);

    // Reset during SEP after a_o went high.
    in_valid = 1'b1;
    in_a = 1'b1;
    in_b = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_a_before", int'(a_o), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    out_i = 1'b0;
    chk("midrst_a_o", int'(a_o), 0);
    chk("midrst_clk_o", int'(clk_o), 0);
    chk("midrst_spur_err", int'(spur_err), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    spur_exp = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    res_n = 0;
    rdy_ok = 1;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (res_valid === 1'b1) res_n++;
      if (in_ready !== 1'b1) rdy_ok = 0;
    end
    @(negedge clk);
    chk("midrst_no_result", res_n, 0);
    chk("midrst_ready_held", rdy_ok, 1);
    chk("midrst_a_stays_0", int'(a_o), 0);
    run_op(1'b1, 1'b1, 32'h0000_0000, -1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
